// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture path.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS_HI,
    WAIT_VS_LO,
    CAPTURE
  } cam_state_e;

  // RGB565 field positions within an assembled pixel
  localparam int RGB_R_LSB = 11;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 5;

  // Ceiling log2, clamped to 1 so derived port widths never collapse to zero
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser with registered-history edge detect.
module cam_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      q    <= '0;
      prev <= '0;
    end else begin
      s1   <= d;
      q    <= s1;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/camera_capture_buf.sv
// OV7670 capture: oversampled pins, pixel assembly, decimation and a
// ping-pong frame buffer read through a registered random-access port.
module camera_capture_buf
  import cam_pkg::*;
#(
  parameter int CAM_W     = 640,
  parameter int CAM_H     = 480,
  parameter int DEC_SHIFT = 2,
  parameter int PIX_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 work_en,
  input  logic                                 ov_pclk,
  input  logic                                 ov_vs,
  input  logic                                 ov_hs,
  input  logic [7:0]                           cam_data,
  output logic                                 ov_rst,
  output logic                                 ov_pwdn,
  input  logic [clog2(CAM_W >> DEC_SHIFT)-1:0] rd_x,
  input  logic [clog2(CAM_H >> DEC_SHIFT)-1:0] rd_y,
  output logic [PIX_W-1:0]                     rd_q,
  output logic                                 frame_ready,
  output logic                                 frame_valid,
  output logic [15:0]                          frame_cnt,
  output logic [15:0]                          drop_cnt
);

  localparam int BUF_W = CAM_W >> DEC_SHIFT;
  localparam int BUF_H = CAM_H >> DEC_SHIFT;
  localparam int AW    = clog2(BUF_W * BUF_H);
  localparam int XW    = clog2(CAM_W) + 1;
  localparam int YW    = clog2(CAM_H) + 1;
  localparam int DMASK = (1 << DEC_SHIFT) - 1;
  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;

  assign ov_rst  = rst;
  assign ov_pwdn = 1'b0;

  logic       pclk_s, pclk_rise;
  logic       vs_s, vs_rise;
  logic       hs_s, hs_fall;
  logic [7:0] data_s;

  cam_sync_edge #(.W(1)) u_sync_pclk (
    .clk(clk), .rst(rst), .d(ov_pclk), .q(pclk_s), .rise(pclk_rise), .fall()
  );
  cam_sync_edge #(.W(1)) u_sync_vs (
    .clk(clk), .rst(rst), .d(ov_vs), .q(vs_s), .rise(vs_rise), .fall()
  );
  cam_sync_edge #(.W(1)) u_sync_hs (
    .clk(clk), .rst(rst), .d(ov_hs), .q(hs_s), .rise(), .fall(hs_fall)
  );
  cam_sync_edge #(.W(8)) u_sync_data (
    .clk(clk), .rst(rst), .d(cam_data), .q(data_s), .rise(), .fall()
  );

  cam_state_e state, nxt;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          phase, bad, wr_bank;
  logic [7:0]    hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = work_en ? WAIT_VS_HI : IDLE;
      WAIT_VS_HI: if (vs_s)    nxt = WAIT_VS_LO;
      WAIT_VS_LO: if (!vs_s)   nxt = CAPTURE;
      CAPTURE:    if (vs_rise) nxt = WAIT_VS_LO;
      default:    nxt = IDLE;
    endcase
    if (!work_en) nxt = IDLE;
  end

  logic          in_frame, byte_evt, pix_evt, oob, aligned, we;
  logic [15:0]   pix16;
  logic [AW-1:0] waddr, raddr;

  assign in_frame = (state == CAPTURE) && (nxt == CAPTURE);
  assign byte_evt = in_frame && !hs_fall && pclk_rise && hs_s;
  assign pix_evt  = byte_evt && phase;
  assign oob      = (32'(x) >= CAM_W) || (32'(y) >= CAM_H);
  assign aligned  = ((32'(x) & DMASK) == 0) && ((32'(y) & DMASK) == 0);
  assign we       = pix_evt && !oob && aligned;
  assign pix16    = {hi, data_s};
  assign waddr    = AW'((32'(y) >> DEC_SHIFT) * BUF_W + (32'(x) >> DEC_SHIFT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      bad         <= 1'b0;
      hi          <= '0;
      wr_bank     <= 1'b0;
      frame_ready <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      frame_ready <= 1'b0;
      if (state == WAIT_VS_LO && nxt == CAPTURE) begin
        x     <= '0;
        y     <= '0;
        phase <= 1'b0;
        bad   <= 1'b0;
      end else if (in_frame) begin
        if (hs_fall) begin
          // a line only counts if it actually delivered pixels
          phase <= 1'b0;
          if (x != '0) begin
            x <= '0;
            if (y != YMAX) y <= y + 1'b1;
          end
        end else if (byte_evt) begin
          phase <= ~phase;
          if (!phase) hi <= data_s;
          else begin
            if (oob) bad <= 1'b1;
            if (x != XMAX) x <= x + 1'b1;
          end
        end
      end else if (state == CAPTURE && nxt == WAIT_VS_LO) begin
        if (!bad && 32'(y) == CAM_H) begin
          wr_bank     <= ~wr_bank;
          frame_ready <= 1'b1;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + 1'b1;
        end else begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  // Both banks share one array; the bank bit selects the half, so the
  // writer and reader can never collide on the same bank.
  logic [PIX_W-1:0] mem [0:(2 << AW)-1];
  logic [PIX_W-1:0] mem_q;
  logic             rd_ok;

  assign raddr = AW'(32'(rd_y) * BUF_W + 32'(rd_x));

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, waddr}] <= pix16[PIX_W-1:0];
    mem_q <= mem[{~wr_bank, raddr}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_ok <= 1'b0;
    else      rd_ok <= frame_valid && (32'(rd_x) < BUF_W) && (32'(rd_y) < BUF_H);
  end

  assign rd_q = rd_ok ? mem_q : '0;

endmodule

// File: tb/tb_camera_capture_buf.sv
// Directed bench for camera_capture_buf at 8x4 sensor, 2x decimation.
module tb_camera_capture_buf;

  logic        clk, rst, work_en, ov_pclk, ov_vs, ov_hs;
  logic [7:0]  cam_data;
  logic        ov_rst, ov_pwdn;
  logic [1:0]  rd_x;
  logic [0:0]  rd_y;
  logic [15:0] rd_q;
  logic        frame_ready, frame_valid;
  logic [15:0] frame_cnt, drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int fr_pulses = 0;
  logic pp_on = 1'b0;
  logic pp_seen = 1'b0;

  camera_capture_buf #(.CAM_W(8), .CAM_H(4), .DEC_SHIFT(1), .PIX_W(16)) dut (
    .clk(clk), .rst(rst), .work_en(work_en), .ov_pclk(ov_pclk), .ov_vs(ov_vs),
    .ov_hs(ov_hs), .cam_data(cam_data), .ov_rst(ov_rst), .ov_pwdn(ov_pwdn),
    .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  initial begin clk = 0;     forever #5  clk = ~clk; end
  initial begin ov_pclk = 0; forever #40 ov_pclk = ~ov_pclk; end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) if (frame_ready === 1'b1) fr_pulses++;

  // Display bank (0,0) must flip cleanly from old to new frame, one cycle after the swap pulse.
  always @(negedge clk) begin
    if (pp_on) begin
      chk("pingpong_rd00", 32'(rd_q), pp_seen ? 32'h1000 : 32'h0);
      if (frame_ready === 1'b1) pp_seen = 1'b1;
    end
  end

  task automatic pclks(input int n);
    repeat (n) @(negedge ov_pclk);
  endtask

  task automatic cam_line(input int npx, input logic [7:0] yv, input logic [15:0] add);
    for (int i = 0; i < npx; i++) begin
      logic [15:0] p;
      p = {yv, 8'(i)} + add;
      @(negedge ov_pclk); ov_hs = 1'b1; cam_data = p[15:8];
      @(negedge ov_pclk); cam_data = p[7:0];
    end
    @(negedge ov_pclk); ov_hs = 1'b0; cam_data = 8'h00;
    pclks(3);
  endtask

  task automatic cam_frame(input int nlines, input int long_line, input logic [15:0] add);
    @(negedge ov_pclk); ov_vs = 1'b0;
    pclks(3);
    for (int l = 0; l < nlines; l++) cam_line((l == long_line) ? 10 : 8, 8'(l), add);
    pclks(2);
    ov_vs = 1'b1;
    pclks(6);
  endtask

  task automatic rd_chk(input string tag, input int bx, input int by, input logic [15:0] exp);
    @(negedge clk); rd_x = 2'(bx); rd_y = 1'(by);
    @(posedge clk); #1;
    chk(tag, 32'(rd_q), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; work_en = 1'b0; ov_vs = 1'b1; ov_hs = 1'b0; cam_data = 8'h00;
    rd_x = '0; rd_y = '0;
    repeat (5) @(posedge clk); #1;
    chk("rst_rd_q", 32'(rd_q), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_ov_rst", 32'(ov_rst), 0);
    chk("rst_ov_pwdn", 32'(ov_pwdn), 0);

    @(negedge clk); rst = 1'b1; work_en = 1'b1;
    #1 chk("run_ov_rst", 32'(ov_rst), 1);
    pclks(4);

    // good frame: stored (bx,by) comes from sensor (2bx,2by) = 0x0200*by + 2*bx
    fr_pulses = 0;
    cam_frame(4, -1, 16'h0000);
    chk("f1_pulses", fr_pulses, 1);
    chk("f1_frame_cnt", 32'(frame_cnt), 1);
    chk("f1_frame_valid", 32'(frame_valid), 1);
    chk("f1_drop_cnt", 32'(drop_cnt), 0);
    rd_chk("f1_rd_1_1", 1, 1, 16'h0202);
    for (int by = 0; by < 2; by++)
      for (int bx = 0; bx < 4; bx++)
        rd_chk("f1_rd_all", bx, by, 16'(16'h0200 * by + 2 * bx));

    // ping-pong swap observed on every cycle of the second frame
    @(negedge clk); rd_x = 2'd0; rd_y = 1'd0;
    @(negedge clk); pp_seen = 1'b0; pp_on = 1'b1; fr_pulses = 0;
    cam_frame(4, -1, 16'h1000);
    @(negedge clk); pp_on = 1'b0;
    chk("f2_swap_seen", 32'(pp_seen), 1);
    chk("f2_pulses", fr_pulses, 1);
    chk("f2_frame_cnt", 32'(frame_cnt), 2);
    rd_chk("f2_rd_1_1", 1, 1, 16'h1202);
    rd_chk("f2_rd_3_1", 3, 1, 16'h1206);

    // short frame: three lines only
    fr_pulses = 0;
    cam_frame(3, -1, 16'h2000);
    chk("short_drop_cnt", 32'(drop_cnt), 1);
    chk("short_frame_cnt", 32'(frame_cnt), 2);
    chk("short_pulses", fr_pulses, 0);
    rd_chk("short_rd_1_1", 1, 1, 16'h1202);

    // overlong line 2 (10 pixels)
    cam_frame(4, 2, 16'h2000);
    chk("long_drop_cnt", 32'(drop_cnt), 2);
    chk("long_frame_cnt", 32'(frame_cnt), 2);
    chk("long_pulses", fr_pulses, 0);
    rd_chk("long_rd_2_1", 2, 1, 16'h1204);

    // work_en dropped mid line 1, then restored while the frame is still running
    fork
      cam_frame(4, -1, 16'h2000);
      begin pclks(28); work_en = 1'b0; pclks(2); work_en = 1'b1; end
    join
    chk("abort_frame_cnt", 32'(frame_cnt), 2);
    chk("abort_drop_cnt", 32'(drop_cnt), 2);
    chk("abort_pulses", fr_pulses, 0);
    rd_chk("abort_rd_1_1", 1, 1, 16'h1202);

    cam_frame(4, -1, 16'h3000);
    chk("resume_frame_cnt", 32'(frame_cnt), 3);
    chk("resume_drop_cnt", 32'(drop_cnt), 2);
    chk("resume_pulses", fr_pulses, 1);
    rd_chk("resume_rd_1_1", 1, 1, 16'h3202);
    rd_chk("resume_rd_0_0", 0, 0, 16'h3000);
    rd_chk("resume_rd_3_1", 3, 1, 16'h3206);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/camera_capture_buf.md
Name: camera_capture_buf

Overview:
Parametrised OV7670 capture block, successor to the fixed 640x480 capture path. Runs entirely in the system clock domain:
- Oversamples the raw camera pins and assembles two-byte pixels.
- Decimates by a configurable power of two on each axis.
- Writes into a ping-pong frame buffer, so the consumer always reads a complete, tear-free frame through a registered random-access read port.

Parameters:
CAM_W, 640, active pixels per line from sensor
CAM_H, 480, active lines per frame
DEC_SHIFT, 2, decimation factor 2^DEC_SHIFT on both axes (0 = none)
PIX_W, 16, stored pixel width; low PIX_W bits of assembled 16-bit pixel (PIX_W <= 16)
BUF_W, CAM_W>>DEC_SHIFT, derived, stored columns
BUF_H, CAM_H>>DEC_SHIFT, derived, stored rows
AW, clog2(BUF_W*BUF_H), derived, bank address width

Ports:
clk  in  1  system clock, must be >= 4x ov_pclk frequency
rst  in  1  asynchronous active-low reset
work_en  in  1  capture enable
ov_pclk  in  1  raw camera pixel clock (asynchronous)
ov_vs  in  1  raw camera VSYNC, high = blanking
ov_hs  in  1  raw camera HREF, high = active byte
cam_data  in  8  raw camera data byte
ov_rst  out  1  camera reset (active low), equals rst
ov_pwdn  out  1  camera powerdown, constant 0
rd_x  in  clog2(BUF_W)  read column
rd_y  in  clog2(BUF_H)  read row
rd_q  out  PIX_W  read data, from display bank
frame_ready  out  1  one-cycle pulse on bank swap
frame_valid  out  1  high once any frame has completed
frame_cnt  out  16  completed-frame counter, wraps 0xFFFF->0
drop_cnt  out  16  discarded-frame counter, wraps

Behaviour:
- Reset (rst=0, async): all outputs 0 except ov_rst=0; FSM=IDLE; wr_bank=0; x=y=0; byte phase=0.
- Input conditioning: ov_pclk, ov_vs, ov_hs, cam_data pass through two flops each.
  - pclk_rise = sync_pclk & ~prev_sync_pclk.
  - hs and data are sampled only on the pclk_rise cycle.
- FSM states:
  - IDLE -> WAIT_VS_HI when work_en=1.
  - WAIT_VS_HI -> WAIT_VS_LO when sync_vs=1.
  - WAIT_VS_LO -> CAPTURE when sync_vs=0; x=y=0, phase=0, bad=0 on entry.
  - CAPTURE -> WAIT_VS_LO on sync_vs rising edge (frame end).
  - Any state -> IDLE on work_en=0. A partial frame is discarded: no swap, no drop_cnt increment.
- CAPTURE pixel assembly:
  - On pclk_rise with hs=1: phase 0 latches the high byte; phase 1 forms pixel = {hi, byte}.
  - Phase toggles on every sampled byte.
- Line end: on hs falling edge (synced), if x!=0 then y<=y+1, x<=0. Phase is forced to 0 regardless of x.
- Pixel handling: each pixel increments x. The pixel is written to bank wr_bank at address (y>>DEC_SHIFT)*BUF_W + (x>>DEC_SHIFT) only if x[DEC_SHIFT-1:0]==0 and y[DEC_SHIFT-1:0]==0.
- Bounds: if x>=CAM_W or y>=CAM_H when a pixel arrives, there is no write and bad<=1.
- Frame end: if bad=0 and y==CAM_H, the frame is good.
  - Good frame: wr_bank toggles; frame_ready pulses for 1 cycle; frame_cnt++; frame_valid<=1.
  - Otherwise: drop_cnt++ and wr_bank is unchanged.
- Read port: 1-cycle latency. rd_q registered from bank ~wr_bank at rd_y*BUF_W+rd_x.
  - rd_q=0 if frame_valid=0, rd_x>=BUF_W, or rd_y>=BUF_H.
  - A read in the same cycle as a swap returns data from the old display bank. From the next cycle, reads use the new bank.
- Storage: two banks of BUF_W*BUF_H x PIX_W, inferred single-write/single-read RAM. Write and read always target different banks.
- Arithmetic: x width clog2(CAM_W)+1; y width clog2(CAM_H)+1. Both saturate at max and never wrap mid-frame.

Decomposition:
- Package cam_pkg: FSM state enum (IDLE, WAIT_VS_HI, WAIT_VS_LO, CAPTURE), RGB565 field constants, clog2 helper.
- One sub-module cam_sync_edge: parametrised-width 2-flop synchroniser with rise/fall outputs. Instanced for pclk, vs, hs, and data (data uses width 8, edge outputs unused).

Test Plan:
All scenarios use CAM_W=8, CAM_H=4, DEC_SHIFT=1, clk = 8x pclk.
- Reset: hold rst=0 -> rd_q=0, frame_cnt=0, frame_valid=0, ov_rst=0, ov_pwdn=0.
- Good frame: drive pixel n = 16'h0100*y + x (4 lines x 8 px) -> exactly one frame_ready pulse, frame_cnt=1. Reading (rd_x=1, rd_y=1) returns 16'h0202 one cycle later; all 8 stored locations match.
- Ping-pong: second frame with pixels +16'h1000, reading (0,0) every cycle -> 16'h0000 until the cycle after frame_ready, then 16'h1000; no mixed values.
- Short frame (3 lines) -> drop_cnt=1, frame_cnt unchanged, rd_q still returns the previous frame.
- Overlong line (10 px) -> frame dropped, drop_cnt increments, no writes beyond address 7.
- work_en dropped mid-line, then re-raised -> FSM returns to IDLE and waits a full vsync cycle. The next complete frame gives frame_cnt+1 and drop_cnt is unchanged.
